// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: one-hot FSM states, owner encoding, default widths.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_RESP = 4'b0100,
    ST_DLV  = 4'b1000
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on ties using a last-grant pointer; otherwise fixed data priority.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   accept_i,
`endif
  input  logic   i_valid_i,
  input  logic   d_valid_i,
  output logic   any_valid_o,
  output owner_e winner_o
);

  assign any_valid_o = i_valid_i | d_valid_i;

`ifdef MEM_ARB_RR_EN
  owner_e last_q, last_d;

  always_comb begin
    winner_o = OWN_I;
    if (d_valid_i && (!i_valid_i || last_q == OWN_I)) winner_o = OWN_D;
  end

  always_comb begin
    last_d = last_q;
    if (accept_i) last_d = winner_o;
  end

  // Resetting to "fetch last" makes the first tie go to data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= OWN_I;
    else      last_q <= last_d;
  end
`else
  always_comb begin
    winner_o = OWN_I;
    if (d_valid_i) winner_o = OWN_D;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (default: data over fetch).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rdata_valid,
  input  logic                i_rdata_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_wen,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rdata_valid,
  input  logic                d_rdata_ready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_wen,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rdata_valid,
  output logic                m_rdata_ready,
  output logic                d_busy,
  output state_e              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // a valid source holds its payload stable until that edge, and ready may depend on valid.

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              winner;
  logic                any_valid;
  logic                accept;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
`endif
    .i_valid_i   (i_req_valid),
    .d_valid_i   (d_req_valid),
    .any_valid_o (any_valid),
    .winner_o    (winner)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    buf_d         = buf_q;
    accept        = 1'b0;
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    m_req_valid   = 1'b0;
    m_rdata_ready = 1'b0;
    i_rdata_valid = 1'b0;
    d_rdata_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          accept  = 1'b1;
          owner_d = winner;
          state_d = ST_REQ;
          if (winner == OWN_D) begin
            d_req_ready = 1'b1;
            addr_d      = d_req_addr;
            wen_d       = d_req_wen;
            wdata_d     = d_req_wdata;
            wstrb_d     = d_req_wstrb;
          end else begin
            i_req_ready = 1'b1;
            addr_d      = i_req_addr;
            wen_d       = 1'b0;
            wdata_d     = '0;
            wstrb_d     = '0;
          end
        end
      end
      ST_REQ: begin
        m_req_valid = 1'b1;
        if (m_req_ready) state_d = wen_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        m_rdata_ready = 1'b1;
        if (m_rdata_valid) begin
          buf_d   = m_rdata;
          state_d = ST_DLV;
        end
      end
      ST_DLV: begin
        i_rdata_valid = (owner_q == OWN_I);
        d_rdata_valid = (owner_q == OWN_D);
        if ((owner_q == OWN_I) ? i_rdata_ready : d_rdata_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_D;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      buf_q   <= buf_d;
    end
  end

  assign m_addr    = addr_q;
  assign m_wen     = wen_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign i_rdata   = buf_q;
  assign d_rdata   = buf_q;
  assign d_busy    = (owner_q == OWN_D) && (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; tie expectations follow MEM_ARB_RR_EN when defined.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] i_req_addr;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rdata_valid;
  logic        i_rdata_ready;
  logic [31:0] d_req_addr;
  logic        d_req_wen;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rdata_valid;
  logic        d_rdata_ready;
  logic [31:0] m_addr;
  logic        m_wen;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_req_valid;
  logic        m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rdata_valid;
  logic        m_rdata_ready;
  logic        d_busy;
  state_e      dbg_state;

  int tests = 0;
  int fails = 0;
  // {owner (1 = data), data}
  logic [32:0] exp_q[$];
  logic        last_d_m;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_addr    (i_req_addr),
    .i_req_valid   (i_req_valid),
    .i_req_ready   (i_req_ready),
    .i_rdata       (i_rdata),
    .i_rdata_valid (i_rdata_valid),
    .i_rdata_ready (i_rdata_ready),
    .d_req_addr    (d_req_addr),
    .d_req_wen     (d_req_wen),
    .d_req_wdata   (d_req_wdata),
    .d_req_wstrb   (d_req_wstrb),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_rdata       (d_rdata),
    .d_rdata_valid (d_rdata_valid),
    .d_rdata_ready (d_rdata_ready),
    .m_addr        (m_addr),
    .m_wen         (m_wen),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_rdata       (m_rdata),
    .m_rdata_valid (m_rdata_valid),
    .m_rdata_ready (m_rdata_ready),
    .d_busy        (d_busy),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Memory-side driver: starts in REQ, grants the request, answers after rsp_wait idle cycles.
  // Returns at the negedge where the arbiter is in DLV.
  task automatic mem_read(input logic [31:0] data, input int rsp_wait);
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0;
    repeat (rsp_wait) @(negedge clk);
    m_rdata_valid = 1'b1;
    m_rdata       = data;
    @(negedge clk);
    m_rdata_valid = 1'b0;
    m_rdata       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({m_req_valid, m_rdata_ready, i_rdata_valid, d_rdata_valid, d_busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_valids: got %b want 00000",
               {m_req_valid, m_rdata_ready, i_rdata_valid, d_rdata_valid, d_busy});
    end
    tests++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0 || m_wen !== 1'b0 ||
        i_rdata !== 32'h0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_regs: addr=%h wdata=%h wstrb=%h wen=%b rdata=%h state=%b want all 0, IDLE",
               m_addr, m_wdata, m_wstrb, m_wen, i_rdata, dbg_state);
    end
    rst = 1'b1;
    last_d_m = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    logic [32:0] exp;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h100;
    #1;
    tests++;
    if ({i_req_ready, d_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL fetch_accept: ready i/d=%b want 10", {i_req_ready, d_req_ready});
    end
    exp_q.push_back({1'b0, 32'h0000_0013});
    last_d_m = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_addr  = 32'hFFFF_FFFC;
    #1;
    tests++;
    if (m_req_valid !== 1'b1 || m_addr !== 32'h100 || m_wen !== 1'b0 || m_wstrb !== 4'h0 ||
        i_req_ready !== 1'b0 || d_busy !== 1'b0) begin
      fails++;
      $display("FAIL fetch_req: valid=%b addr=%h wen=%b wstrb=%h rdy=%b busy=%b want 1 100 0 0 0 0",
               m_req_valid, m_addr, m_wen, m_wstrb, i_req_ready, d_busy);
    end
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0;
    tests++;
    if (m_rdata_ready !== 1'b1 || m_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_resp: m_rdata_ready=%b m_req_valid=%b want 1 0", m_rdata_ready, m_req_valid);
    end
    @(negedge clk);
    m_rdata_valid = 1'b1;
    m_rdata       = 32'h0000_0013;
    @(negedge clk);
    m_rdata_valid = 1'b0;
    m_rdata       = '0;
    exp = exp_q.pop_front();
    tests++;
    if (i_rdata_valid !== 1'b1 || d_rdata_valid !== 1'b0 || i_rdata !== exp[31:0] || d_busy !== 1'b0) begin
      fails++;
      $display("FAIL fetch_dlv: ivalid=%b dvalid=%b rdata=%h busy=%b want 1 0 %h 0",
               i_rdata_valid, d_rdata_valid, i_rdata, d_busy, exp[31:0]);
    end
    i_rdata_ready = 1'b1;
    @(negedge clk);
    i_rdata_ready = 1'b0;
    tests++;
    if (i_rdata_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL fetch_done: ivalid=%b state=%b want 0 IDLE", i_rdata_valid, dbg_state);
    end
  endtask

  task automatic test_load_stall();
    logic [32:0] exp;
    d_req_valid = 1'b1;
    d_req_wen   = 1'b0;
    d_req_addr  = 32'h2100;
    #1;
    tests++;
    if ({d_req_ready, i_req_ready} !== 2'b10) begin
      fails++;
      $display("FAIL load_accept: ready d/i=%b want 10", {d_req_ready, i_req_ready});
    end
    exp_q.push_back({1'b1, 32'h5555_AAAA});
    last_d_m = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b0;
    d_req_addr  = '0;
    tests++;
    if (d_busy !== 1'b1 || m_req_valid !== 1'b1 || m_addr !== 32'h2100 || m_wen !== 1'b0) begin
      fails++;
      $display("FAIL load_req: busy=%b valid=%b addr=%h wen=%b want 1 1 2100 0",
               d_busy, m_req_valid, m_addr, m_wen);
    end
    mem_read(32'h5555_AAAA, 0);
    exp = exp_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (d_rdata_valid !== 1'b1 || i_rdata_valid !== 1'b0 || d_rdata !== exp[31:0] || d_busy !== 1'b1) begin
        fails++;
        $display("FAIL load_hold[%0d]: dvalid=%b ivalid=%b rdata=%h busy=%b want 1 0 %h 1",
                 k, d_rdata_valid, i_rdata_valid, d_rdata, d_busy, exp[31:0]);
      end
      @(negedge clk);
    end
    d_rdata_ready = 1'b1;
    @(negedge clk);
    d_rdata_ready = 1'b0;
    tests++;
    if (d_rdata_valid !== 1'b0 || d_busy !== 1'b0) begin
      fails++;
      $display("FAIL load_done: dvalid=%b busy=%b want 0 0", d_rdata_valid, d_busy);
    end
    m_rdata_valid = 1'b1;
    m_rdata       = 32'hBAD0_BAD0;
    @(negedge clk);
    m_rdata_valid = 1'b0;
    tests++;
    if (dbg_state !== ST_IDLE || d_rdata_valid !== 1'b0 || i_rdata_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_stray_rdata: state=%b dvalid=%b ivalid=%b want IDLE 0 0",
               dbg_state, d_rdata_valid, i_rdata_valid);
    end
  endtask

  // Both requesters stay valid across three back-to-back rounds.
  task automatic test_tie();
    logic        exp_d;
    logic [32:0] exp;
    logic [31:0] d_addr;
    logic [31:0] i_addr;
    d_addr      = 32'h2000;
    i_addr      = 32'h104;
    d_req_wen   = 1'b0;
    d_req_wdata = '0;
    d_req_wstrb = '0;
    for (int r = 0; r < 3; r++) begin
      d_req_valid = 1'b1;
      i_req_valid = 1'b1;
      d_req_addr  = d_addr;
      i_req_addr  = i_addr;
      exp_d = RR_EN ? !last_d_m : 1'b1;
      #1;
      tests++;
      if ({d_req_ready, i_req_ready} !== {exp_d, !exp_d}) begin
        fails++;
        $display("FAIL tie_grant[%0d]: ready d/i=%b want %b", r, {d_req_ready, i_req_ready}, {exp_d, !exp_d});
      end
      exp_q.push_back({exp_d, 32'hA000_0000 + 32'(r)});
      last_d_m = exp_d;
      @(negedge clk);
      tests++;
      if (m_addr !== (exp_d ? d_addr : i_addr) || d_busy !== exp_d) begin
        fails++;
        $display("FAIL tie_req[%0d]: addr=%h busy=%b want %h %b",
                 r, m_addr, d_busy, exp_d ? d_addr : i_addr, exp_d);
      end
      if (exp_d) d_addr = d_addr + 32'h4;
      else       i_addr = i_addr + 32'h4;
      d_req_addr = d_addr;
      i_req_addr = i_addr;
      mem_read(32'hA000_0000 + 32'(r), 1);
      exp = exp_q.pop_front();
      tests++;
      if ({d_rdata_valid, i_rdata_valid} !== {exp[32], !exp[32]} ||
          (exp[32] ? d_rdata : i_rdata) !== exp[31:0]) begin
        fails++;
        $display("FAIL tie_dlv[%0d]: valid d/i=%b data=%h want %b %h",
                 r, {d_rdata_valid, i_rdata_valid}, exp[32] ? d_rdata : i_rdata,
                 {exp[32], !exp[32]}, exp[31:0]);
      end
      if (exp[32]) d_rdata_ready = 1'b1;
      else         i_rdata_ready = 1'b1;
      #1;
      tests++;
      if ({d_req_ready, i_req_ready} !== 2'b00) begin
        fails++;
        $display("FAIL tie_no_accept_in_dlv[%0d]: ready d/i=%b want 00", r, {d_req_ready, i_req_ready});
      end
      @(negedge clk);
      d_rdata_ready = 1'b0;
      i_rdata_ready = 1'b0;
    end
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
  endtask

  task automatic test_store();
    logic [32:0] exp;
    d_req_valid = 1'b1;
    d_req_wen   = 1'b1;
    d_req_addr  = 32'h3000;
    d_req_wdata = 32'hDEAD_BEEF;
    d_req_wstrb = 4'hF;
    m_req_ready = 1'b0;
    #1;
    tests++;
    if (d_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL store_accept: d_req_ready=%b want 1", d_req_ready);
    end
    last_d_m = 1'b1;
    @(negedge clk);
    d_req_valid = 1'b0;
    d_req_wen   = 1'b0;
    d_req_addr  = 32'h0BAD;
    d_req_wdata = '0;
    d_req_wstrb = '0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (m_req_valid !== 1'b1 || m_addr !== 32'h3000 || m_wdata !== 32'hDEAD_BEEF ||
          m_wstrb !== 4'hF || m_wen !== 1'b1 || d_busy !== 1'b1) begin
        fails++;
        $display("FAIL store_hold[%0d]: valid=%b addr=%h wdata=%h wstrb=%h wen=%b busy=%b",
                 k, m_req_valid, m_addr, m_wdata, m_wstrb, m_wen, d_busy);
      end
      m_rdata_valid = (k == 1);
      @(negedge clk);
      m_rdata_valid = 1'b0;
    end
    m_req_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (dbg_state !== ST_IDLE || m_rdata_ready !== 1'b0 || m_req_valid !== 1'b0 ||
        d_rdata_valid !== 1'b0 || d_busy !== 1'b0) begin
      fails++;
      $display("FAIL store_done: state=%b mrr=%b mrv=%b dvalid=%b busy=%b want IDLE 0 0 0 0",
               dbg_state, m_rdata_ready, m_req_valid, d_rdata_valid, d_busy);
    end
    // Zero-wait store followed by a fetch accepted two cycles after the store's accept.
    d_req_valid = 1'b1;
    d_req_wen   = 1'b1;
    d_req_addr  = 32'h3004;
    d_req_wdata = 32'h1234_5678;
    d_req_wstrb = 4'h3;
    @(negedge clk);
    d_req_valid = 1'b0;
    d_req_wen   = 1'b0;
    tests++;
    if (m_req_valid !== 1'b1 || m_addr !== 32'h3004 || m_wstrb !== 4'h3 || m_wdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL store2_req: valid=%b addr=%h wstrb=%h wdata=%h want 1 3004 3 12345678",
               m_req_valid, m_addr, m_wstrb, m_wdata);
    end
    @(negedge clk);
    m_req_ready = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h200;
    #1;
    tests++;
    if (i_req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL store2_next_accept: i_req_ready=%b state=%b want 1 IDLE", i_req_ready, dbg_state);
    end
    exp_q.push_back({1'b0, 32'h0000_0093});
    last_d_m = 1'b0;
    @(negedge clk);
    i_req_valid = 1'b0;
    tests++;
    if (m_addr !== 32'h200 || m_wen !== 1'b0 || m_wstrb !== 4'h0) begin
      fails++;
      $display("FAIL b2b_fetch_req: addr=%h wen=%b wstrb=%h want 200 0 0", m_addr, m_wen, m_wstrb);
    end
    mem_read(32'h0000_0093, 0);
    exp = exp_q.pop_front();
    tests++;
    if (i_rdata_valid !== 1'b1 || d_rdata_valid !== 1'b0 || i_rdata !== exp[31:0]) begin
      fails++;
      $display("FAIL b2b_fetch_dlv: ivalid=%b dvalid=%b rdata=%h want 1 0 %h",
               i_rdata_valid, d_rdata_valid, i_rdata, exp[31:0]);
    end
    i_rdata_ready = 1'b1;
    @(negedge clk);
    i_rdata_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_req_valid = 1'b1;
    d_req_wen   = 1'b0;
    d_req_addr  = 32'h2200;
    @(negedge clk);
    d_req_valid = 1'b0;
    m_req_ready = 1'b1;
    @(negedge clk);
    m_req_ready = 1'b0;
    tests++;
    if (dbg_state !== ST_RESP || m_rdata_ready !== 1'b1 || d_busy !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre: state=%b mrr=%b busy=%b want RESP 1 1", dbg_state, m_rdata_ready, d_busy);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({m_rdata_ready, m_req_valid, d_busy, d_rdata_valid, i_rdata_valid} !== 5'b0 ||
        m_addr !== 32'h0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL rstmid_async: valids=%b addr=%h state=%b want 00000 0 IDLE",
               {m_rdata_ready, m_req_valid, d_busy, d_rdata_valid, i_rdata_valid}, m_addr, dbg_state);
    end
    last_d_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_rdata_valid = 1'b1;
    m_rdata       = 32'h7777_7777;
    @(negedge clk);
    m_rdata_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (d_rdata_valid !== 1'b0 || i_rdata_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
        fails++;
        $display("FAIL rstmid_no_resp[%0d]: dvalid=%b ivalid=%b state=%b want 0 0 IDLE",
                 k, d_rdata_valid, i_rdata_valid, dbg_state);
      end
      @(negedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
  endtask

  initial begin
    rst           = 1'b0;
    i_req_addr    = '0;
    i_req_valid   = 1'b0;
    i_rdata_ready = 1'b0;
    d_req_addr    = '0;
    d_req_wen     = 1'b0;
    d_req_wdata   = '0;
    d_req_wstrb   = '0;
    d_req_valid   = 1'b0;
    d_rdata_ready = 1'b0;
    m_req_ready   = 1'b0;
    m_rdata       = '0;
    m_rdata_valid = 1'b0;
    last_d_m      = 1'b0;
    test_reset();
    test_fetch();
    test_load_stall();
    test_tie();
    test_store();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the pipeline's instruction-fetch requester and its data-access (load/store) requester. Each accepted request is registered, issued to memory over a valid/ready request channel, and, for reads, the response is buffered and returned to the originating requester. It sits between the IF/MA stages and the top-level memory interface and is the only driver of that interface.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width; write strobe width is DATA_W/8.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req_addr  in  ADDR_W  fetch address.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_rdata  out  DATA_W  instruction word.
- i_rdata_valid  out  1  instruction word valid.
- i_rdata_ready  in  1  IF ready to take the word.
- d_req_addr  in  ADDR_W  data address.
- d_req_wen  in  1  1 = store, 0 = load.
- d_req_wdata  in  DATA_W  store data.
- d_req_wstrb  in  DATA_W/8  byte strobes.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_rdata  out  DATA_W  load data.
- d_rdata_valid  out  1  load data valid.
- d_rdata_ready  in  1  MA ready to take load data.
- m_addr, m_wen, m_wdata, m_wstrb  out  ADDR_W/1/DATA_W/DATA_W/8  registered request to memory.
- m_req_valid  out  1  memory request valid.
- m_req_ready  in  1  memory accepted request.
- m_rdata  in  DATA_W  memory read data.
- m_rdata_valid  in  1  memory read data valid.
- m_rdata_ready  out  1  arbiter ready for read data.
- d_busy  out  1  data transaction in flight (pipeline stall source).

## Operation
- FSM states: IDLE, REQ, RESP, DLV. One-hot.
- IDLE: if any *_req_valid, pick winner, assert that requester's *_req_ready combinationally (single-cycle pulse), register addr/wen/wdata/wstrb and owner flag; → REQ. Fetches carry wen=0, wstrb=0.
- Pick: default build, data always wins when both valid.
- REQ: m_req_valid=1 from registers, held stable until m_req_ready. On handshake: store → IDLE; load/fetch → RESP.
- RESP: m_rdata_ready=1; on m_rdata_valid capture m_rdata into return buffer → DLV.
- DLV: owner's *_rdata_valid=1, other requester's valid=0; hold buffer until owner's *_rdata_ready → IDLE.
- No new request accepted outside IDLE; both *_req_ready=0 in REQ/RESP/DLV.
- d_busy=1 whenever owner is data and state≠IDLE.
- i_rdata and d_rdata both driven from the shared buffer; only valid qualifies.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; m_req_valid, m_rdata_ready, i_rdata_valid, d_rdata_valid, d_busy=0; m_addr, m_wdata, m_wstrb, m_wen, buffer=0; owner=data; rr pointer=data-first.
- Reset mid-transaction aborts it silently; no response is delivered afterward.
- Accept cycle N → m_req_valid from N+1. Zero-wait memory read: rdata_valid to requester at earliest N+3.
- Store with m_req_ready already high: back in IDLE at N+2, next accept at N+2.
- Back-to-back: DLV→IDLE costs one cycle; no accept in the DLV handshake cycle.
- Requester inputs sampled only in the accept cycle; later changes ignored.
- m_rdata_valid outside RESP is ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin when both request in the same IDLE cycle — winner is the opposite of the last granted owner; pointer updates on every accept. Single requester always wins.
- Undefined: fixed data-over-fetch priority; no pointer register.

## Structure
- Shared package: FSM state constants, owner encoding (OWN_I, OWN_D), default widths.
- One sub-module: mem_arb_pick — combinational winner select, plus the round-robin pointer flop under MEM_ARB_RR_EN.

## Test plan
- Lone fetch 0x100, memory returns 0x00000013 after 2 cycles → i_rdata_valid with 0x00000013, d_rdata_valid stays 0, d_busy 0.
- Simultaneous fetch 0x104 and load 0x2000 (default build) → data granted first, m_addr=0x2000, fetch accepted only after d_rdata handshake.
- Same stimulus, MEM_ARB_RR_EN, previous grant data → fetch granted first; following tie goes to data.
- Store 0x3000 data 0xDEADBEEF wstrb 0xF, m_req_ready delayed 3 cycles → m_* held stable 3 cycles, no response phase, IDLE two cycles after accept when ready=1.
- Load response with d_rdata_ready low 4 cycles → d_rdata_valid and data held constant, d_busy=1 throughout.
- rst asserted while in RESP → all valids 0 immediately, later m_rdata_valid pulse produces no requester response.
